// File: rtl/flex_deser_pkg.sv
// Shared types and helpers for the flex_deser_counted deserialiser.
package flex_deser_pkg;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

    // Words up to 32 bits are zero-extended, which leaves the XOR unchanged.
    function automatic logic word_xor(input logic [31:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/flex_deser_counted_if.sv
// Bit-in / word-out bundle between the receive path, flex_deser_counted and its consumer.
interface flex_deser_counted_if
    import flex_deser_pkg::*;
#(
    parameter int NUM_BITS = 8,
    parameter int CNT_W    = cnt_width(NUM_BITS)
);
    logic                shift_enable;
    logic                serial_in;
    logic                msb_first;
    logic                clear;
    logic                word_ack;
    logic [NUM_BITS-1:0] parallel_out;
    logic [CNT_W-1:0]    bit_count;
    logic [NUM_BITS-1:0] word_out;
    logic                word_valid;
    logic                overrun;
    logic                word_parity;

    modport master (
        output shift_enable, serial_in, msb_first, clear, word_ack,
        input  parallel_out, bit_count, word_out, word_valid, overrun, word_parity
    );

    modport slave (
        input  shift_enable, serial_in, msb_first, clear, word_ack,
        output parallel_out, bit_count, word_out, word_valid, overrun, word_parity
    );
endinterface

// File: rtl/flex_deser_bitcnt.sv
// Bit position counter for flex_deser_counted: counts enabled bits, wraps after NUM_BITS.
module flex_deser_bitcnt #(
    parameter int NUM_BITS = 8,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             last
);
    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(NUM_BITS - 1);

    logic [CNT_W-1:0] count_r;

    assign count = count_r;
    assign last  = (count_r == LAST_VAL);

    // Count register: clear wins over enable, wrap to zero after the last bit.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en) begin
            if (last) begin
                count_r <= {CNT_W{1'b0}};
            end else begin
                count_r <= count_r + CNT_W'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/flex_deser_counted.sv
// Serial-to-parallel deserialiser with bit counter, direction select and word holding register.
// Optional build macro FLEX_DESER_PARITY_EN adds a registered XOR of word_out on word_parity.
module flex_deser_counted
    import flex_deser_pkg::*;
#(
    parameter int NUM_BITS   = 8,
    parameter int RESET_ONES = 1
) (
    input logic                 clk,
    input logic                 n_rst,
    flex_deser_counted_if.slave bus
);
    localparam int CNT_W = cnt_width(NUM_BITS);
    localparam logic [NUM_BITS-1:0] CLEAR_VAL =
        (RESET_ONES != 0) ? {NUM_BITS{1'b1}} : {NUM_BITS{1'b0}};

    logic [NUM_BITS-1:0] shift_r;
    logic [NUM_BITS-1:0] shift_next_s;
    logic [NUM_BITS-1:0] word_r;
    logic                overrun_r;
    logic                last_s;
    logic                complete_s;
    logic [CNT_W-1:0]    count_s;
    out_state_t          state_r;

    flex_deser_bitcnt #(
        .NUM_BITS (NUM_BITS),
        .CNT_W    (CNT_W)
    ) u_bitcnt (
        .clk   (clk),
        .n_rst (n_rst),
        .en    (bus.shift_enable),
        .clr   (bus.clear),
        .count (count_s),
        .last  (last_s)
    );

    assign complete_s = bus.shift_enable & ~bus.clear & last_s;

    // Next shift-register value for the direction sampled this cycle.
    always_comb begin
        shift_next_s = shift_r;
        if (bus.msb_first) begin
            shift_next_s = {shift_r[NUM_BITS-2:0], bus.serial_in};
        end else begin
            shift_next_s = {bus.serial_in, shift_r[NUM_BITS-1:1]};
        end
    end

    // Shift register: never cleared on completion, only by clear or reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shift_r <= CLEAR_VAL;
        end else if (bus.clear) begin
            shift_r <= CLEAR_VAL;
        end else if (bus.shift_enable) begin
            shift_r <= shift_next_s;
        end else begin
            shift_r <= shift_r;
        end
    end

    // Holding FSM, captured word and sticky overrun flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r   <= OUT_EMPTY;
            word_r    <= {NUM_BITS{1'b0}};
            overrun_r <= 1'b0;
        end else begin
            if (complete_s) begin
                word_r <= shift_next_s;
            end else begin
                word_r <= word_r;
            end

            if (bus.clear) begin
                overrun_r <= 1'b0;
            end else if (complete_s && (state_r == OUT_FULL) && !bus.word_ack) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end

            case (state_r)
                OUT_EMPTY: begin
                    if (complete_s) begin
                        state_r <= OUT_FULL;
                    end else begin
                        state_r <= OUT_EMPTY;
                    end
                end
                OUT_FULL: begin
                    if (complete_s) begin
                        state_r <= OUT_FULL;
                    end else if (bus.word_ack) begin
                        state_r <= OUT_EMPTY;
                    end else begin
                        state_r <= OUT_FULL;
                    end
                end
                default: begin
                    state_r <= OUT_EMPTY;
                end
            endcase
        end
    end

`ifdef FLEX_DESER_PARITY_EN
    logic parity_r;

    // Parity is captured alongside word_out so both change on the same edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            parity_r <= 1'b0;
        end else if (complete_s) begin
            parity_r <= word_xor(32'(shift_next_s));
        end else begin
            parity_r <= parity_r;
        end
    end

    assign bus.word_parity = parity_r;
`else
    assign bus.word_parity = 1'b0;
`endif

    assign bus.parallel_out = shift_r;
    assign bus.bit_count    = count_s;
    assign bus.word_out     = word_r;
    assign bus.word_valid   = (state_r == OUT_FULL);
    assign bus.overrun      = overrun_r;

endmodule

// File: tb/tb_flex_deser_counted.sv
// Randomised + directed bench for flex_deser_counted (NUM_BITS=8, RESET_ONES=1) against a word-level model.
module tb_flex_deser_counted;
    localparam int N = 8;

    logic clk;
    logic n_rst;

    flex_deser_counted_if #(.NUM_BITS(N)) bus ();

    flex_deser_counted #(
        .NUM_BITS   (N),
        .RESET_ONES (1)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: word-level view of the deserialiser.
    int unsigned m_par  = 32'hFF;
    int          m_cnt  = 0;
    int unsigned m_word = 0;
    bit          m_full = 1'b0;
    bit          m_ovr  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit exp_parity();
`ifdef FLEX_DESER_PARITY_EN
        return bit'($countones(m_word) % 2);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_par  = 32'hFF;
        m_cnt  = 0;
        m_word = 0;
        m_full = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".par_out"}, 32'(bus.parallel_out), m_par);
        check_eq({tag, ".count"},   32'(bus.bit_count),    32'(m_cnt));
        check_eq({tag, ".word"},    32'(bus.word_out),     m_word);
        check_eq({tag, ".valid"},   32'(bus.word_valid),   32'(m_full));
        check_eq({tag, ".overrun"}, 32'(bus.overrun),      32'(m_ovr));
        check_eq({tag, ".parity"},  32'(bus.word_parity),  32'(exp_parity()));
    endtask

    // One clock cycle: drive inputs, advance the model by the block's rules, then compare.
    task automatic cyc(input string tag, input bit se, input bit sin, input bit msb,
                       input bit clr, input bit ack);
        bit done;
        bus.shift_enable = se;
        bus.serial_in    = sin;
        bus.msb_first    = msb;
        bus.clear        = clr;
        bus.word_ack     = ack;
        @(posedge clk);
        done = 1'b0;
        if (clr) begin
            m_par = 32'hFF;
            m_cnt = 0;
            m_ovr = 1'b0;
        end else if (se) begin
            if (msb) m_par = ((m_par << 1) | 32'(sin)) & 32'hFF;
            else     m_par = (m_par >> 1) | (32'(sin) << (N - 1));
            if (m_cnt == N - 1) begin
                m_cnt = 0;
                done  = 1'b1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        if (done) begin
            if (m_full && !ack) m_ovr = 1'b1;
            m_word = m_par;
            m_full = 1'b1;
        end else if (ack) begin
            m_full = 1'b0;
        end
        #1;
        check_all(tag);
    endtask

    task automatic send_word(input string tag, input logic [7:0] v, input bit msb,
                             input int gap, input bit ack_last);
        for (int i = 0; i < N; i++) begin
            cyc(tag, 1'b1, msb ? v[7 - i] : v[i], msb, 1'b0, ack_last && (i == N - 1));
            for (int g = 0; g < gap; g++) cyc({tag, "_gap"}, 1'b0, 1'b1, msb, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] bits_c0;
        bits_c0 = 8'hC0;
        bus.shift_enable = 1'b0;
        bus.serial_in    = 1'b0;
        bus.msb_first    = 1'b1;
        bus.clear        = 1'b0;
        bus.word_ack     = 1'b0;
        n_rst            = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all("in_reset");
        n_rst = 1'b1;
        cyc("post_reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("reset_par_ff", 32'(bus.parallel_out), 32'hFF);

        // 1,1,0,0,0,0,0,0 MSB-first gives C0
        send_word("msb_c0", bits_c0, 1'b1, 0, 1'b0);
        check_eq("msb_c0_const", 32'(bus.word_out), 32'hC0);
        cyc("ack_c0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Same bit order LSB-first with gaps: first bit lands in [0] -> 03
        for (int i = 0; i < N; i++) begin
            cyc("lsb_03", 1'b1, bits_c0[7 - i], 1'b0, 1'b0, 1'b0);
            for (int g = 0; g < 2; g++) cyc("lsb_03_gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check_eq("lsb_03_const", 32'(bus.word_out), 32'h03);
        cyc("ack_03", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Overrun, ack coinciding with completion, then clear
        send_word("ovr_w1", 8'hC0, 1'b1, 0, 1'b0);
        send_word("ovr_w2", 8'hF0, 1'b1, 0, 1'b0);
        check_eq("ovr_word_f0", 32'(bus.word_out), 32'hF0);
        check_eq("ovr_set", 32'(bus.overrun), 32'h1);
        send_word("ovr_w3", 8'h5A, 1'b1, 0, 1'b1);
        check_eq("ack_last_valid", 32'(bus.word_valid), 32'h1);
        check_eq("ack_last_ovr", 32'(bus.overrun), 32'h1);
        cyc("ovr_clear", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("ovr_cleared", 32'(bus.overrun), 32'h0);

        // Partial word aborted by clear, then a clean word
        cyc("pre_ack", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc("part5", 1'b1, 1'(i), 1'b1, 1'b0, 1'b0);
        cyc("part_clear", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("clear_cnt0", 32'(bus.bit_count), 32'h0);
        check_eq("clear_par_ff", 32'(bus.parallel_out), 32'hFF);
        send_word("after_clr", 8'hA5, 1'b1, 0, 1'b0);
        check_eq("after_clr_a5", 32'(bus.word_out), 32'hA5);

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            cyc("rand", ($urandom % 4) != 0, 1'($urandom), 1'($urandom),
                ($urandom % 32) == 0, ($urandom % 4) == 0);
        end

        // Asynchronous reset mid-word with a word held
        send_word("pre_rst", 8'h3C, 1'b0, 0, 1'b0);
        for (int i = 0; i < 5; i++) cyc("pre_rst5", 1'b1, 1'(i), 1'b1, 1'b0, 1'b0);
        check_eq("pre_rst_valid", 32'(bus.word_valid), 32'h1);
        #2;
        n_rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        check_all("rst_release");
        send_word("post_rst", 8'h81, 1'b1, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flex_deser_counted.md
Name: flex_deser_counted

Overview:
- Parametrised serial-to-parallel deserialiser with a built-in bit counter, runtime-selectable shift direction, and a word holding register with a valid/ack handshake.
- Sits between the bit-level receive path (after NRZI decode/unstuff) and byte-level consumers such as the RX FSM and FIFO write side.
- Replaces hand-built "shift register + external counter + capture" glue.

Parameters:
- NUM_BITS, 8, word width; legal range 2..32.
- RESET_ONES, 1, shift register reset/clear value: 1 = all ones (idle line), 0 = all zeros.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- shift_enable  input  1  sample serial_in this cycle.
- serial_in  input  1  serial data bit.
- msb_first  input  1  direction: 1 = shift toward MSB (new bit at [0]); 0 = shift toward LSB (new bit at [NUM_BITS-1]).
- clear  input  1  synchronous abort of the partial word.
- word_ack  input  1  consumer accepts word_out.
- parallel_out  output  NUM_BITS  live shift register contents.
- bit_count  output  CNT_W  bits accumulated in the current word; CNT_W = $clog2(NUM_BITS).
- word_out  output  NUM_BITS  last completed word (registered).
- word_valid  output  1  word_out holds an unconsumed word.
- overrun  output  1  sticky: a word completed while the previous word was unconsumed.
- word_parity  output  1  XOR of word_out (see Optional Feature).

Behaviour:
- Reset (async, n_rst=0): parallel_out = RESET_ONES ? '1 : '0; bit_count=0; word_out='0; word_valid=0; overrun=0; word_parity=0. Reset mid-word discards all partial state.
- Priority per cycle: clear > shift_enable > hold.
- clear=1: parallel_out returns to its reset value; bit_count=0; overrun=0. word_out and word_valid are unchanged, and word_ack is still honoured that cycle.
- Shift (shift_enable=1, clear=0):
  - msb_first=1: next = {parallel_out[NUM_BITS-2:0], serial_in}.
  - msb_first=0: next = {serial_in, parallel_out[NUM_BITS-1:1]}.
  - msb_first is sampled per shift; changing it mid-word is legal and applies bitwise.
  - bit_count increments.
- Word completion: a shift with bit_count == NUM_BITS-1.
  - On that same edge, word_out <= next shift value, bit_count wraps to 0, and word_valid <= 1.
  - Latency: word_out is visible the cycle after the final bit's edge.
- Holding FSM, states OUT_EMPTY and OUT_FULL; word_valid = (state == OUT_FULL).
  - EMPTY + completion -> FULL.
  - FULL + word_ack, no completion -> EMPTY.
  - FULL + word_ack + completion -> FULL with the new word; overrun is not set.
  - FULL + completion, no ack -> FULL; word_out is overwritten with the newer word; overrun <= 1.
  - word_ack while EMPTY is ignored.
- overrun stays set until clear or reset.
- shift_enable=0: all registers hold; gaps between bits are allowed.
- parallel_out is not cleared on word completion; it keeps shifting continuously.

Optional Feature:
- Macro FLEX_DESER_PARITY_EN.
- Defined: word_parity is registered as ^(captured word) on the completion edge and tracks word_out.
- Undefined: no parity logic is built and word_parity is tied to 0. The port remains present.

Decomposition:
- Package flex_deser_pkg:
  - typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t.
  - Function cnt_width(n) returning $clog2(n).
- One sub-module, flex_deser_bitcnt: parametrised counter with enable, synchronous clear, wrap at NUM_BITS-1, and a combinational "last" flag. The top level holds the shift register, holding FSM, and the optional parity logic.

Test Plan (NUM_BITS=8, RESET_ONES=1):
- Reset asserted then released -> parallel_out=8'hFF, bit_count=0, word_valid=0, overrun=0, word_out=8'h00.
- msb_first=1, 8 consecutive shifts of bits 1,1,0,0,0,0,0,0 -> the cycle after the 8th edge: word_out=8'hC0, word_valid=1, bit_count=0; word_parity=0 when FLEX_DESER_PARITY_EN is defined.
- msb_first=0, same bit sequence with 2-cycle gaps between shifts -> word_out=8'h03, word_valid=1; bit_count holds during the gaps.
- Two full words with no ack (8'hC0 then 8'hF0, msb_first=1) -> word_out=8'hF0, overrun=1. Then word_ack asserted in the same cycle as a third word's last bit -> word_valid stays 1, overrun stays 1. Then clear -> overrun=0.
- After 5 shifted bits, pulse clear -> bit_count=0, parallel_out=8'hFF, word_valid unchanged. Next 8 bits form a complete word correctly.
- After 5 shifted bits with word_valid=1, assert n_rst low for one cycle -> all outputs return to their reset values immediately, without waiting for a clock edge.
